// File: rtl/ws281x_decode.sv
// WS281x line receiver: measures high pulses, classifies bits, assembles pixels MSB-first, flags latch gaps.
// Optional WS281X_DECODE_FILTER_EN inserts a 3-sample majority glitch filter after the synchronizer.
module ws281x_decode #(
  parameter int SYNC_STAGES = 2,
  parameter int PIX_BITS    = 24
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                code_in,
  input  logic [7:0]          thr_cnt_in,
  input  logic [15:0]         rst_cnt_in,
  output logic                bit_vld_out,
  output logic                bit_data_out,
  output logic                pix_vld_out,
  output logic [PIX_BITS-1:0] pix_data_out,
  output logic                frame_rst_out,
  output logic                err_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;
  localparam int BCNT_W = $clog2(PIX_BITS);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(PIX_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   line_s;
  logic                   line_d_r;
  logic                   rise_r;
  logic                   fall_r;
  logic [1:0]             state_r;
  logic [7:0]             hcnt_r;
  logic [15:0]            lcnt_r;
  logic [BCNT_W-1:0]      bcnt_r;
  logic [PIX_BITS-1:0]    sreg_r;
  logic                   bit_s;
  logic [PIX_BITS-1:0]    sreg_nx_s;
  logic                   gap_hit_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronizer chain for the asynchronous line
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], code_in};
    end
  end

`ifdef WS281X_DECODE_FILTER_EN
  logic [1:0] hist_r;
  logic       filt_r;

  // Majority vote over the last three synchronized samples
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_r <= 2'b00;
      filt_r <= 1'b0;
    end else begin
      hist_r <= {hist_r[0], sync_r[SYNC_STAGES-1]};
      filt_r <= maj3(sync_r[SYNC_STAGES-1], hist_r[0], hist_r[1]);
    end
  end

  assign line_s = filt_r;
`else
  assign line_s = sync_r[SYNC_STAGES-1];
`endif

  // Edge detection; edges are registered so line_d_r is the level aligned with them
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_d_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      line_d_r <= line_s;
      rise_r   <= line_s & ~line_d_r;
      fall_r   <= ~line_s & line_d_r;
    end
  end

  assign bit_s     = (hcnt_r >= thr_cnt_in);
  assign sreg_nx_s = {sreg_r[PIX_BITS-2:0], bit_s};
  assign gap_hit_s = (rst_cnt_in != 16'd0) && (lcnt_r == rst_cnt_in);

  // Pulse-measurement FSM with registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r       <= ST_IDLE;
      hcnt_r        <= 8'd0;
      lcnt_r        <= 16'd0;
      bcnt_r        <= '0;
      sreg_r        <= '0;
      bit_vld_out   <= 1'b0;
      bit_data_out  <= 1'b0;
      pix_vld_out   <= 1'b0;
      pix_data_out  <= '0;
      frame_rst_out <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      bit_vld_out   <= 1'b0;
      pix_vld_out   <= 1'b0;
      frame_rst_out <= 1'b0;
      err_out       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          hcnt_r <= 8'd0;
          lcnt_r <= 16'd0;
          if (rise_r) begin
            state_r <= ST_HIGH;
            hcnt_r  <= 8'd1;
          end
        end
        ST_HIGH: begin
          if (fall_r) begin
            state_r      <= ST_LOW;
            lcnt_r       <= 16'd1;
            bit_vld_out  <= 1'b1;
            bit_data_out <= bit_s;
            sreg_r       <= sreg_nx_s;
            if (bcnt_r == BCNT_LAST) begin
              pix_vld_out  <= 1'b1;
              pix_data_out <= sreg_nx_s;
              bcnt_r       <= '0;
            end else begin
              bcnt_r <= bcnt_r + BCNT_W'(1);
            end
          end else if (line_d_r) begin
            if (hcnt_r == 8'd254) begin
              hcnt_r  <= 8'd255;
              err_out <= 1'b1;
              sreg_r  <= '0;
              bcnt_r  <= '0;
              state_r <= ST_ERR;
            end else if (hcnt_r != 8'd255) begin
              hcnt_r <= hcnt_r + 8'd1;
            end
          end
        end
        ST_LOW: begin
          // A gap that completes on the same cycle as a rise still reports, then follows the rise
          if (gap_hit_s) begin
            frame_rst_out <= 1'b1;
            bcnt_r        <= '0;
            sreg_r        <= '0;
            lcnt_r        <= 16'd0;
            if (rise_r) begin
              state_r <= ST_HIGH;
              hcnt_r  <= 8'd1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (rise_r) begin
            state_r <= ST_HIGH;
            hcnt_r  <= 8'd1;
            lcnt_r  <= 16'd0;
          end else if (lcnt_r != 16'hFFFF) begin
            lcnt_r <= lcnt_r + 16'd1;
          end
        end
        ST_ERR: begin
          if (fall_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ws281x_decode.md
Name: ws281x_decode

Overview:
- Receive-side counterpart of the WS281x bit encoder: samples a serial WS281x line, measures each high pulse, classifies it as 0 or 1, and assembles pixels MSB-first.
- Detects the low reset/latch gap that ends a frame.
- Used for loopback self-test of the LED output path and for accepting a daisy-chained upstream WS281x stream.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on code_in (min 2)
PIX_BITS, 24, bits per pixel (24 RGB, 32 RGBW)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous, active-low
code_in  input  1  asynchronous WS281x line
thr_cnt_in  input  8  high-time threshold in clk cycles: high count >= thr -> bit 1
rst_cnt_in  input  16  low cycles that constitute a reset gap; 0 disables gap detection
bit_vld_out  output  1  one-cycle pulse per decoded bit
bit_data_out  output  1  decoded bit, valid with bit_vld_out
pix_vld_out  output  1  one-cycle pulse when PIX_BITS bits assembled
pix_data_out  output  PIX_BITS  assembled pixel, first-received bit in MSB, held until next pix_vld_out
frame_rst_out  output  1  one-cycle pulse when reset gap detected
err_out  output  1  one-cycle pulse: high pulse saturated at 255 cycles

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Line path: code_in -> SYNC_STAGES flops -> s. One more flop gives s_d. rise = s & ~s_d, fall = ~s & s_d.
- hcnt: 8-bit, saturating at 255. lcnt: 16-bit, saturating at 65535. bcnt: bit index 0..PIX_BITS-1. sreg: PIX_BITS shift register.
- IDLE: hcnt = 0, lcnt = 0. On rise -> HIGH with hcnt <= 1.
- HIGH: while s = 1, hcnt increments (saturating).
  - On fall -> LOW with lcnt <= 1.
  - bit = (hcnt >= thr_cnt_in), using hcnt before the fall cycle's update.
  - The same edge registers bit_vld_out = 1, bit_data_out = bit, and sreg <= {sreg[PIX_BITS-2:0], bit}.
  - If bcnt == PIX_BITS-1: pix_vld_out = 1, pix_data_out = shifted value, bcnt <= 0. Otherwise bcnt increments.
  - If hcnt reaches 255 while s = 1: err_out pulses once, sreg and bcnt clear, -> ERR.
- LOW: lcnt increments (saturating).
  - On rise -> HIGH with hcnt <= 1; lcnt discarded.
  - If rst_cnt_in != 0 and lcnt == rst_cnt_in: frame_rst_out pulses, bcnt and sreg clear (partial pixel dropped), -> IDLE.
- ERR: no outputs. On fall -> IDLE. A frame is only re-acquired on the next rise.
- Latency: code_in falling edge first sampled at clock edge k -> bit_vld_out high after clock edge k+SYNC_STAGES+1, for one cycle. pix_vld_out is coincident with the PIX_BITS-th bit_vld_out.
- frame_rst_out is never coincident with bit_vld_out. A gap ending exactly at a rise still fires frame_rst_out if lcnt reached rst_cnt_in first.
- thr_cnt_in = 0: every bit decodes as 1.
- thr_cnt_in and rst_cnt_in are sampled live and must be static during a frame.
- Asynchronous reset mid-pixel: sreg, bcnt, outputs and FSM return to reset values immediately. After reset, decoding restarts on the next rise.
- Reset gap in IDLE: no repeated frame_rst_out pulses.

Optional Feature:
- Macro: WS281X_DECODE_FILTER_EN.
- Defined: a 3-sample majority filter is inserted after the synchronizer. The filter output replaces s. Single-cycle glitches are rejected. Latency grows by 2 cycles (bit_vld_out after edge k+SYNC_STAGES+3).
- Not defined: s is the raw synchronizer output. Latency is as stated in Behaviour.

Test Plan:
- Single 0 bit: thr=30, rst_cnt=2500, drive high 20 / low 42 cycles -> bit_vld_out pulse with bit_data_out=0, SYNC_STAGES+1 cycles after the falling edge.
- Pixel: stream 0xA5C33C (T1H=40, T0H=20, period 62) then low 3000 -> 24 bit_vld_out pulses, pix_vld_out with pix_data_out=0xA5C33C on the 24th, then exactly one frame_rst_out 2500 cycles after the last fall.
- Threshold boundary: thr=30, high 29 then high 30 -> bits 0, 1.
- Partial pixel: 10 bits then low 2500 -> frame_rst_out, no pix_vld_out. The next 24 bits 0xFFFFFF -> pix_data_out=0xFFFFFF (no stale bits).
- Stuck high: line high 300 cycles -> err_out single pulse at hcnt=255, no bit_vld_out. After release and a clean pixel, normal decode resumes.
- Reset mid-pixel: assert rst_n_in after 12 bits -> outputs 0. A following full pixel 0x123456 decodes correctly. With WS281X_DECODE_FILTER_EN defined, 1-cycle high glitches inside low periods produce no bit_vld_out.
